// File: rtl/cordic_hyp_if.sv
// Operand/result handshake bundle for the hyperbolic CORDIC rotator.
`timescale 1ns/1ps
interface cordic_hyp_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [W-1:0] z_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic [W-1:0] z_out;

  modport master (
    output in_valid, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out
  );

  modport slave (
    input  in_valid, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_hyp_rotator.sv
// Iterative hyperbolic CORDIC, rotation mode, expanded-range schedule.
// One micro-rotation per clock; Q8.24 operands, W+2 bit x/y datapath.
`timescale 1ns/1ps
module cordic_hyp_rotator #(
  parameter int FLOAT_SIZE = 24,
  parameter int INT_SIZE   = 8
) (
  input  logic        clk,
  input  logic        rst,
  cordic_hyp_if.slave io
);
  localparam int W  = INT_SIZE + FLOAT_SIZE;
  localparam int XW = W + 2;

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_e;

  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic signed [XW-1:0] x_q, x_d;
  logic signed [XW-1:0] y_q, y_d;
  logic signed [W-1:0]  z_q, z_d;

  logic signed [5:0]    idx;
  logic                 expd;
  logic [4:0]           sh;
  logic                 neg;
  logic signed [XW-1:0] tx, ty;
  logic signed [XW:0]   xs, ys;
  logic signed [W-1:0]  ang, z_rot;

  function automatic logic signed [W-1:0] atanh_rom(
    input logic signed [5:0] i
  );
    logic [31:0] v;
    case (i)
      -6'sd3:  v = 32'h0212523d;
      -6'sd2:  v = 32'h01b78ce5;
      -6'sd1:  v = 32'h015aa164;
      6'sd0:   v = 32'h00f91395;
      6'sd1:   v = 32'h008c9f54;
      6'sd2:   v = 32'h004162bc;
      6'sd3:   v = 32'h00202b12;
      6'sd4:   v = 32'h00100559;
      6'sd5:   v = 32'h000800ab;
      6'sd6:   v = 32'h00040015;
      6'sd7:   v = 32'h00020003;
      6'sd8:   v = 32'h00010000;
      6'sd9:   v = 32'h00008000;
      6'sd10:  v = 32'h00004000;
      6'sd11:  v = 32'h00002000;
      6'sd12:  v = 32'h00001000;
      6'sd13:  v = 32'h00000800;
      default: v = 32'h0;
    endcase
    return W'(v);
  endfunction

  // Clamp instead of wrapping so huge magnitudes still saturate at the output.
  function automatic logic signed [XW-1:0] clamp(
    input logic signed [XW:0] v
  );
    if (v[XW] != v[XW-1])
      return v[XW] ? {1'b1, {(XW-1){1'b0}}}
                   : {1'b0, {(XW-1){1'b1}}};
    return v[XW-1:0];
  endfunction

  function automatic logic [W-1:0] sat(
    input logic signed [XW-1:0] v
  );
    if (&v[XW-1:W-1] || ~|v[XW-1:W-1])
      return v[W-1:0];
    return v[XW-1] ? {1'b1, {(W-1){1'b0}}}
                   : {1'b0, {(W-1){1'b1}}};
  endfunction

  always_comb begin
    idx = 6'sd13;
    unique case (1'b1)
      (cnt_q <= 5'd7):
        idx = $signed({1'b0, cnt_q}) - 6'sd3;
      (cnt_q == 5'd8):
        idx = 6'sd4;
      (cnt_q >= 5'd9 && cnt_q <= 5'd17):
        idx = $signed({1'b0, cnt_q}) - 6'sd4;
      default:
        idx = 6'sd13;
    endcase
  end

  always_comb begin
    expd  = (idx <= 6'sd0);
    sh    = expd ? 5'(6'sd2 - idx) : idx[4:0];
    neg   = z_q[W-1];
    tx    = expd ? (y_q - (y_q >>> sh)) : (y_q >>> sh);
    ty    = expd ? (x_q - (x_q >>> sh)) : (x_q >>> sh);
    xs    = neg ? ({x_q[XW-1], x_q} - {tx[XW-1], tx})
                : ({x_q[XW-1], x_q} + {tx[XW-1], tx});
    ys    = neg ? ({y_q[XW-1], y_q} - {ty[XW-1], ty})
                : ({y_q[XW-1], y_q} + {ty[XW-1], ty});
    ang   = atanh_rom(idx);
    z_rot = neg ? (z_q + ang) : (z_q - ang);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          x_d     = {{2{io.x_in[W-1]}}, io.x_in};
          y_d     = {{2{io.y_in[W-1]}}, io.y_in};
          z_d     = io.z_in;
          cnt_d   = '0;
          state_d = ROT;
        end
      end
      ROT: begin
        // Count 19 is a settle slot: result lands 20 edges after accept.
        if (cnt_q == 5'd19) begin
          state_d = DONE;
        end else begin
          x_d   = clamp(xs);
          y_d   = clamp(ys);
          z_d   = z_rot;
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE: begin
        if (io.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.x_out     = sat(x_q);
  assign io.y_out     = sat(y_q);
  assign io.z_out     = z_q;
endmodule
